// File: rtl/prog_loader.sv
// Program loader: assembles a host byte stream (16-bit word count, then MSB-first words)
// into memory writes and holds the core in reset until the image is complete.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; core reset reflects outcome of last load
// HDR_HI  | accepting word-count high byte
// HDR_LO  | accepting word-count low byte; zero/range decision
// DATA    | accepting bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// DONE    | one-cycle completion pulse; core released
// ERR     | range violation; sticky err set, core stays in reset
module prog_loader #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] base_addr,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NBYTES - 1);
  localparam int EXT_W = ADDRSIZE + 17;
  localparam logic [EXT_W-1:0] MEMSIZE_EXT = EXT_W'(1) << ADDRSIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]    word_q, word_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                err_q, err_d;

  logic                xfer;
  logic [15:0]         cnt_full;
  logic [EXT_W-1:0]    end_ext;
  logic [WIDTH-1:0]    word_shift;

  // in_ready depends on registered state only
  assign in_ready  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign err       = err_q;

  assign xfer       = in_valid & in_ready;
  assign cnt_full   = {cnt_q[15:8], in_data};
  assign end_ext    = EXT_W'(addr_q) + EXT_W'(cnt_full);
  assign word_shift = (word_q << 8) | WIDTH'(in_data);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    word_d      = word_q;
    bidx_d      = bidx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_HDR_HI;
          addr_d      = base_addr;
          cpu_reset_d = 1'b1;
          err_d       = 1'b0;
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          cnt_d[15:8] = in_data;
          state_d     = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer) begin
          cnt_d = cnt_full;
          if (cnt_full == 16'd0) begin
            state_d     = S_DONE;
            cpu_reset_d = 1'b0;
          end else if (end_ext > MEMSIZE_EXT) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            bidx_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = word_shift;
          if (bidx_q == LAST_IDX) begin
            state_d     = S_WRITE;
            mem_addr_d  = addr_q;
            mem_wdata_d = word_shift;
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDRSIZE'(1);
        cnt_d  = cnt_q - 16'd1;
        bidx_d = '0;
        if (cnt_q == 16'd1) begin
          state_d     = S_DONE;
          cpu_reset_d = 1'b0;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      bidx_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      err_q       <= err_d;
    end
  end

endmodule
